// File: rtl/gemm_result_drain_pkg.sv
// Shared sizing constants and state encoding for the GEMM result drain.
package gemm_result_drain_pkg;

    localparam int ACC_BANKS  = 4;
    localparam int ACC_LANES  = 4;
    localparam int ACC_W      = 32;

    // One drained vector is all lanes of one bank, written as a single beat.
    localparam int VEC_W      = ACC_LANES * ACC_W;
    // Byte offset between consecutive banks within a row: log2(bytes per vector).
    localparam int BANK_SHIFT = $clog2(VEC_W / 8);
    localparam int BANK_IDX_W = $clog2(ACC_BANKS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_FIN
    } drain_state_t;

endpackage

// File: rtl/gemm_result_drain.sv
// Pops finished accumulator vectors row by row, bank by bank, and writes each
// one as a single wide request on a valid/ready memory port at a strided address.
module gemm_result_drain
    import gemm_result_drain_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ROWS_W = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [ADDR_W-1:0]                            base_addr,
    input  logic [ADDR_W-1:0]                            stride,
    input  logic [ROWS_W-1:0]                            num_rows,
    input  logic [2:0]                                   n_banks,
    input  logic [ACC_BANKS-1:0]                         acc_empty,
    output logic [ACC_BANKS-1:0]                         acc_rd_en,
    input  logic [ACC_BANKS-1:0][ACC_LANES-1:0][ACC_W-1:0] acc_data,
    output logic                                         mem_valid,
    input  logic                                         mem_ready,
    output logic [ADDR_W-1:0]                            mem_addr,
    output logic [VEC_W-1:0]                             mem_wdata,
    output logic                                         busy,
    output logic                                         done
);

    drain_state_t          state_reg;
    drain_state_t          state_next;

    // Latched tile configuration.
    logic [ADDR_W-1:0]     stride_reg;
    logic [ROWS_W-1:0]     num_rows_reg;
    logic [2:0]            n_banks_reg;

    // Loop position and running row address.
    logic [ROWS_W-1:0]     row_reg;
    logic [2:0]            bank_reg;
    logic [ADDR_W-1:0]     row_base_reg;

    // Holding registers for the request presented in WR.
    logic [ADDR_W-1:0]     addr_reg;
    logic [VEC_W-1:0]      data_reg;

    logic [2:0]            n_banks_sat;
    logic [BANK_IDX_W-1:0] bank_idx;
    logic [ADDR_W-1:0]     bank_offset;
    logic                  last_bank;
    logic                  last_row;
    logic                  launch;
    logic                  handshake;

    // More than four banks requested means all four.
    assign n_banks_sat = (n_banks > 3'd4) ? 3'd4 : n_banks;
    assign bank_idx    = bank_reg[BANK_IDX_W-1:0];
    assign bank_offset = ADDR_W'(bank_reg) << BANK_SHIFT;
    assign last_bank   = (bank_reg == n_banks_reg - 3'd1);
    assign last_row    = (row_reg == num_rows_reg - ROWS_W'(1));
    assign launch      = (state_reg == ST_IDLE) && start;
    assign handshake   = (state_reg == ST_WR) && mem_ready;

    assign mem_addr    = addr_reg;
    assign mem_wdata   = data_reg;
    assign busy        = (state_reg != ST_IDLE);

    // State register; reset abandons any in-flight vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus the strobes decoded from the current state.
    always_comb begin
        state_next = state_reg;
        acc_rd_en  = '0;
        mem_valid  = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if ((num_rows == '0) || (n_banks == 3'd0)) begin
                        state_next = ST_FIN;
                    end else begin
                        state_next = ST_RD;
                    end
                end
            end
            ST_RD: begin
                // Pop only a bank that has data; otherwise wait here.
                if (!acc_empty[bank_idx]) begin
                    acc_rd_en[bank_idx] = 1'b1;
                    state_next          = ST_CAP;
                end
            end
            ST_CAP: begin
                state_next = ST_WR;
            end
            ST_WR: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    state_next = (last_bank && last_row) ? ST_FIN : ST_RD;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Config latch, loop counters, address generation and data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_reg   <= '0;
            num_rows_reg <= '0;
            n_banks_reg  <= '0;
            row_reg      <= '0;
            bank_reg     <= '0;
            row_base_reg <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
        end else begin
            if (launch) begin
                stride_reg   <= stride;
                num_rows_reg <= num_rows;
                n_banks_reg  <= n_banks_sat;
                row_reg      <= '0;
                bank_reg     <= '0;
                row_base_reg <= base_addr;
            end
            if (state_reg == ST_CAP) begin
                // Data from the pop issued in RD is valid now; freeze it with its address.
                data_reg <= acc_data[bank_idx];
                addr_reg <= row_base_reg + bank_offset;
            end
            if (handshake) begin
                if (last_bank) begin
                    bank_reg     <= '0;
                    row_reg      <= row_reg + ROWS_W'(1);
                    row_base_reg <= row_base_reg + stride_reg;
                end else begin
                    bank_reg <= bank_reg + 3'd1;
                end
            end
        end
    end

endmodule
